// File: rtl/qam_frame_pkg.sv
// rtl/qam_frame_pkg.sv - frame markers, field offsets and unpacker state shared by the QAM packer and unpacker
package qam_frame_pkg;

    localparam int MARK_WIDTH = 4;
    localparam logic [MARK_WIDTH-1:0] SOF_MARK = 4'b1111;
    localparam logic [MARK_WIDTH-1:0] EOF_MARK = 4'b0101;

    // Frame layout, MSB to LSB: {SOF, addr, symbol, EOF}
    function automatic int sym_lsb();
        return MARK_WIDTH;
    endfunction

    function automatic int addr_lsb(input int data_width);
        return MARK_WIDTH + data_width;
    endfunction

    function automatic int sof_lsb(input int data_width, input int addr_width);
        return MARK_WIDTH + data_width + addr_width;
    endfunction

    function automatic int frame_width(input int data_width, input int addr_width);
        return data_width + addr_width + 2 * MARK_WIDTH;
    endfunction

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/sym_skid_fifo.sv
// rtl/sym_skid_fifo.sv - 2-entry valid/ready FIFO with a registered input ready
module sym_skid_fifo #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push       = in_valid && ready_q;
    assign pop        = (count != 2'd0) && out_ready;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    // ready is computed from the next occupancy so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/frame_unpacker.sv
// rtl/frame_unpacker.sv - QAM frame unpacker: marker check, address sequence lock, symbol recovery
module frame_unpacker
    import qam_frame_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int START_ADDR  = 0,
    parameter int MAX_MISS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int FRAME_WIDTH = DATA_WIDTH + ADDR_WIDTH + 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [FRAME_WIDTH-1:0] data_in,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [ADDR_WIDTH-1:0]  addr_out,
    output logic                   locked,
    output logic [CNT_WIDTH-1:0]   err_marker_cnt,
    output logic [CNT_WIDTH-1:0]   err_seq_cnt
);

    localparam int SYM_LSB  = sym_lsb();
    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int SOF_LSB  = sof_lsb(DATA_WIDTH, ADDR_WIDTH);
    localparam int MISS_W   = $clog2(MAX_MISS + 1);
    localparam logic [ADDR_WIDTH-1:0] START   = ADDR_WIDTH'(START_ADDR);
    localparam logic [MISS_W-1:0]     LAST_MISS = MISS_W'(MAX_MISS - 1);

    unpack_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] expected_q, expected_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic [CNT_WIDTH-1:0]  err_marker_q, err_marker_d;
    logic [CNT_WIDTH-1:0]  err_seq_q, err_seq_d;
    logic                  push;

    logic [MARK_WIDTH-1:0] frame_sof;
    logic [MARK_WIDTH-1:0] frame_eof;
    logic [ADDR_WIDTH-1:0] frame_addr;
    logic [DATA_WIDTH-1:0] frame_sym;
    logic                  accept;
    logic                  marker_ok;

    assign frame_sof  = data_in[SOF_LSB +: MARK_WIDTH];
    assign frame_eof  = data_in[MARK_WIDTH-1:0];
    assign frame_addr = data_in[ADDR_LSB +: ADDR_WIDTH];
    assign frame_sym  = data_in[SYM_LSB +: DATA_WIDTH];
    assign accept     = valid_in && ready_out;
    assign marker_ok  = (frame_sof == SOF_MARK) && (frame_eof == EOF_MARK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= UNLOCKED;
            expected_q   <= START;
            miss_q       <= '0;
            err_marker_q <= '0;
            err_seq_q    <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            miss_q       <= miss_d;
            err_marker_q <= err_marker_d;
            err_seq_q    <= err_seq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        miss_d       = miss_q;
        err_marker_d = err_marker_q;
        err_seq_d    = err_seq_q;
        push         = 1'b0;
        if (accept) begin
            if (!marker_ok) begin
                if (err_marker_q != '1) begin
                    err_marker_d = err_marker_q + CNT_WIDTH'(1);
                end
            end else begin
                case (state_q)
                    UNLOCKED: begin
                        // Off-start frames are ignored silently while hunting for a stream start
                        if (frame_addr == START) begin
                            push       = 1'b1;
                            expected_d = frame_addr + ADDR_WIDTH'(1);
                            miss_d     = '0;
                            state_d    = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (frame_addr == expected_q) begin
                            push       = 1'b1;
                            expected_d = expected_q + ADDR_WIDTH'(1);
                            miss_d     = '0;
                        end else begin
                            if (err_seq_q != '1) begin
                                err_seq_d = err_seq_q + CNT_WIDTH'(1);
                            end
                            if (miss_q == LAST_MISS) begin
                                state_d    = UNLOCKED;
                                expected_d = START;
                                miss_d     = '0;
                            end else begin
                                miss_d = miss_q + MISS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                    end
                endcase
            end
        end
    end

    sym_skid_fifo #(
        .WIDTH(ADDR_WIDTH + DATA_WIDTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (push),
        .in_ready (ready_out),
        .in_data  ({frame_addr, frame_sym}),
        .out_valid(valid_out),
        .out_ready(ready_in),
        .out_data ({addr_out, data_out})
    );

    assign locked         = (state_q == LOCKED);
    assign err_marker_cnt = err_marker_q;
    assign err_seq_cnt    = err_seq_q;

endmodule

// File: tb/tb_frame_unpacker.sv
// tb/tb_frame_unpacker.sv - scoreboard bench for frame_unpacker
module tb_frame_unpacker;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int FW = DW + AW + 8;
    localparam int CW = 16;
    localparam logic [3:0] SOF = 4'b1111;
    localparam logic [3:0] EOF = 4'b0101;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [FW-1:0] data_in = '0;
    logic          valid_out;
    logic          ready_in = 1'b1;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_out;
    logic          locked;
    logic [CW-1:0] err_marker_cnt;
    logic [CW-1:0] err_seq_cnt;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] sym;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_mis = 0;

    frame_unpacker #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .START_ADDR(0),
        .MAX_MISS  (4),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .data_in       (data_in),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .data_out      (data_out),
        .addr_out      (addr_out),
        .locked        (locked),
        .err_marker_cnt(err_marker_cnt),
        .err_seq_cnt   (err_seq_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL unexpected_output: got addr %0h sym %0h, expected none", addr_out, data_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_addr", 32'(addr_out), 32'(mon_e.addr));
                check("out_data", 32'(data_out), 32'(mon_e.sym));
            end
        end
    end

    function automatic logic [DW-1:0] sym_of(input logic [AW-1:0] a);
        return a ^ 4'hC;
    endfunction

    // Returns at posedge+1 after the frame is taken by the DUT
    task automatic send(input logic [3:0] sof, input logic [AW-1:0] a, input logic [DW-1:0] s,
                        input logic [3:0] eof, input bit expect_push);
        int waitc = 0;
        exp_t e;
        data_in  = {sof, a, s, eof};
        valid_in = 1'b1;
        @(negedge clk);
        while (!ready_out && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        if (!ready_out) begin
            check("send_timeout", 32'(ready_out), 32'd1);
            valid_in = 1'b0;
            return;
        end
        if (expect_push) begin
            e = '{addr: a, sym: s};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid_out", 32'(valid_out), 32'd0);
    endtask

    initial begin
        int  k;
        time t0;

        // reset state
        #1;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_ready_out", 32'(ready_out), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_marker", 32'(err_marker_cnt), 32'd0);
        check("rst_err_seq", 32'(err_seq_cnt), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(ready_out), 32'd1);

        // bad SOF then a good start frame, whose output appears one cycle later
        send(4'b1110, 4'd0, 4'hA, EOF, 1'b0);
        check("bad_sof_cnt", 32'(err_marker_cnt), 32'd1);
        check("bad_sof_locked", 32'(locked), 32'd0);
        send(SOF, 4'd0, 4'h3, EOF, 1'b1);
        check("latency_valid_out", 32'(valid_out), 32'd1);
        check("latency_data_out", 32'(data_out), 32'h3);
        check("first_locked", 32'(locked), 32'd1);

        // bad EOF leaves the expected address alone
        send(SOF, 4'd1, 4'h5, 4'b0100, 1'b0);
        check("bad_eof_cnt", 32'(err_marker_cnt), 32'd2);

        // stream 1..7 at one frame per cycle
        t0 = $time;
        for (int i = 1; i < 8; i++) begin
            send(SOF, 4'(i), 4'(2 * i + 3), EOF, 1'b1);
        end
        check("throughput_cycles", 32'(($time - t0) / 10), 32'd7);
        check("stream_locked", 32'(locked), 32'd1);
        check("stream_err_seq", 32'(err_seq_cnt), 32'd0);

        // expected=8: three misses then the right address
        for (int i = 0; i < 3; i++) begin
            send(SOF, 4'd9, 4'h1, EOF, 1'b0);
        end
        check("miss3_err_seq", 32'(err_seq_cnt), 32'd3);
        check("miss3_locked", 32'(locked), 32'd1);
        send(SOF, 4'd8, 4'h7, EOF, 1'b1);
        check("recover_locked", 32'(locked), 32'd1);

        // expected=9: four misses drop lock, fifth is silently dropped
        for (int i = 0; i < 4; i++) begin
            send(SOF, 4'd3, 4'h2, EOF, 1'b0);
        end
        check("lost_locked", 32'(locked), 32'd0);
        check("lost_err_seq", 32'(err_seq_cnt), 32'd7);
        send(SOF, 4'd3, 4'h2, EOF, 1'b0);
        check("unlocked_err_seq", 32'(err_seq_cnt), 32'd7);
        check("unlocked_err_marker", 32'(err_marker_cnt), 32'd2);
        send(SOF, 4'd0, 4'h6, EOF, 1'b1);
        check("relock", 32'(locked), 32'd1);
        drain();

        // backpressure: expected=1, only two frames fit
        ready_in = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            data_in  = {SOF, 4'(1 + k), sym_of(4'(1 + k)), EOF};
            valid_in = 1'b1;
            @(negedge clk);
            if (k > 0) begin
                check("bp_hold_data", 32'(data_out), 32'(sym_of(4'd1)));
            end
            if (ready_out) begin
                exp_q.push_back('{addr: 4'(1 + k), sym: sym_of(4'(1 + k))});
                k++;
            end
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        check("bp_accepted", 32'(k), 32'd2);
        check("bp_ready_out", 32'(ready_out), 32'd0);
        check("bp_addr_out", 32'(addr_out), 32'd1);
        ready_in = 1'b1;
        drain();

        // address wrap: expected=3, run through 15 into 0 and 1
        for (int i = 3; i < 18; i++) begin
            send(SOF, 4'(i), sym_of(4'(i)), EOF, 1'b1);
        end
        check("wrap_err_seq", 32'(err_seq_cnt), 32'd7);
        check("wrap_locked", 32'(locked), 32'd1);
        drain();

        // reset with two entries buffered
        ready_in = 1'b0;
        send(SOF, 4'd2, 4'h8, EOF, 1'b1);
        send(SOF, 4'd3, 4'h9, EOF, 1'b1);
        check("pre_rst_ready_out", 32'(ready_out), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_valid_out", 32'(valid_out), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_err_seq", 32'(err_seq_cnt), 32'd0);
        check("midrst_err_marker", 32'(err_marker_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid_out", 32'(valid_out), 32'd0);
        check("post_rst_ready_out", 32'(ready_out), 32'd1);
        ready_in = 1'b1;
        send(SOF, 4'd5, 4'h4, EOF, 1'b0);
        check("post_rst_off_start", 32'(locked), 32'd0);
        check("post_rst_no_out", 32'(valid_out), 32'd0);
        send(SOF, 4'd0, 4'hE, EOF, 1'b1);
        check("post_rst_relock", 32'(locked), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/frame_unpacker.md
Name: frame_unpacker

Overview:
- Receive side of the QAM link; sits directly downstream of the frame packer and consumes its packed frames.
- Checks the start and end markers, tracks the address sequence, and recovers the DATA_WIDTH symbol and its address.
- Hands the recovered symbol to the demapper or sink through a 2-entry output buffer with valid/ready.
- Keeps saturating error counters and a lock indicator for debug and ILA.

Parameters:
DATA_WIDTH, 4, symbol width in bits
ADDR_WIDTH, 32, frame address field width
START_ADDR, 0, address of the first frame of a stream
MAX_MISS, 4, consecutive sequence mismatches before lock is dropped (>=1)
CNT_WIDTH, 16, error counter width
FRAME_WIDTH, DATA_WIDTH+ADDR_WIDTH+8, packed frame width (derived; do not override)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous active-low reset
valid_in  in  1  upstream frame valid
ready_out  out  1  ready to upstream
data_in  in  FRAME_WIDTH  packed frame, laid out MSB to LSB as {SOF 4'b1111, addr, symbol, EOF 4'b0101}
valid_out  out  1  symbol valid to downstream
ready_in  in  1  downstream ready
data_out  out  DATA_WIDTH  recovered symbol
addr_out  out  ADDR_WIDTH  address of data_out
locked  out  1  high while in LOCKED
err_marker_cnt  out  CNT_WIDTH  frames with a bad SOF or EOF
err_seq_cnt  out  CNT_WIDTH  well-formed frames with an unexpected address while LOCKED

Behaviour:
- Reset (rst low, asynchronous): all outputs are 0 and the buffer is empty; state is UNLOCKED; expected address is START_ADDR; miss counter is 0. ready_out rises on the first clock edge after rst deasserts.
- Input handshake: a frame is accepted when valid_in && ready_out. ready_out = (buffer count < 2) and is driven from a register only; there is no combinational path from ready_in.
- Marker check: a frame is good only if bits [FRAME_WIDTH-1 -: 4] == 4'b1111 and bits [3:0] == 4'b0101.
- Bad-marker frame: dropped; err_marker_cnt increments (saturating); state and expected address are unchanged.
- FSM states: UNLOCKED and LOCKED.
  - UNLOCKED, good frame with addr == START_ADDR: push the frame to the buffer, expected := addr+1, go to LOCKED.
  - UNLOCKED, good frame with any other addr: drop it silently; no counter changes.
  - LOCKED, good frame with addr == expected: push it, expected := expected+1, miss counter := 0.
  - LOCKED, good frame with addr != expected: drop it, err_seq_cnt increments, miss counter increments.
  - LOCKED, when the miss counter reaches MAX_MISS: go to UNLOCKED, expected := START_ADDR.
- Address arithmetic is modulo 2^ADDR_WIDTH: after the all-ones address the expected address is 0.
- Output buffer: 2-entry FIFO holding {addr, symbol}. valid_out = buffer not empty. data_out and addr_out come from the head entry.
- Latency: a frame accepted at edge N appears on valid_out after edge N (1 cycle) when the buffer was empty.
- Throughput: sustains 1 frame per cycle when ready_in is held high.
- Backpressure: with ready_in low, the buffer fills after 2 pushes and ready_out falls. While valid_out && !ready_in, data_out and addr_out are held stable.
- Simultaneous push and pop: count is unchanged and FIFO order is preserved.
- Counters saturate at all-ones and do not wrap.
- locked is registered and equals (state == LOCKED).
- A reset assertion mid-stream empties the buffer immediately and discards any partially tracked sequence.

Decomposition:
- Shared package qam_frame_pkg:
  - SOF_MARK = 4'b1111 and EOF_MARK = 4'b0101
  - frame field offset functions for DATA_WIDTH and ADDR_WIDTH
  - state enum unpack_state_t {UNLOCKED, LOCKED}
  - The packer imports the same markers, so both ends share one definition.
- One sub-module is natural: sym_skid_fifo, a parameterized 2-entry valid/ready FIFO of width ADDR_WIDTH+DATA_WIDTH, with the same asynchronous active-low reset.

Test Plan:
- Stream of frames with addr 0..7, symbols 0x3,0x5,..., and ready_in=1 -> valid_out high from cycle 2 on; data_out/addr_out match in order; locked=1 after the first frame; both counters stay 0.
- Frame with SOF=4'b1110, then addr 0 -> first frame dropped, err_marker_cnt=1, second frame output, locked=1.
- While locked at expected=5, send addr 9 three times and then addr 5 (MAX_MISS=4) -> err_seq_cnt=3, the addr 5 frame is output, miss counter is cleared, locked stays 1.
- Five consecutive addr 9 frames while locked -> after the 4th, locked=0; the 5th is dropped with no counter change; an addr 0 frame relocks.
- Hold ready_in=0 for 5 cycles with valid_in=1 -> exactly 2 frames accepted, ready_out=0 and data_out stable; releasing ready_in drains both entries in order with no loss.
- START_ADDR=0, ADDR_WIDTH=4, frames addr 0..15 then 0 -> wrap accepted with no seq error. Separately, assert rst mid-stream with 2 entries buffered -> valid_out=0 immediately and the buffer is empty after deassert.
